// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// and the quotient pattern returned on divide-by-zero.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } muldiv_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } muldiv_state_t;

   // Replicated to the datapath width, so the all-ones quotient follows WIDTH.
   localparam logic DIV0_QUOT_BIT = 1'b1;

endpackage

// File: rtl/muldiv_abs.sv
// Combinational conditional two's-complement negate; zero latency, no flow control.
// Gives |x| when neg is the operand's signed-and-negative flag, or applies a result sign.
module muldiv_abs
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic             neg,
   output logic [WIDTH-1:0] y
);

   assign y = neg ? (~x + 1'b1) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; result WIDTH+1 cycles after start, MTHI/MTLO same edge.
// No queuing: start is ignored while busy (busy stalls the pipeline); flush aborts without writing.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] opr_a,
   input  logic [WIDTH-1:0] opr_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   muldiv_state_t      state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;     // {hi-acc, multiplier} or {rem, quot}
   logic [WIDTH-1:0]   opd_q, opd_d;     // multiplicand or divisor magnitude
   logic               neg_q, neg_d;     // product / quotient sign
   logic               neg_r_q, neg_r_d; // remainder sign
   logic               dz_q, dz_d;
   logic               is_div_q, is_div_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   logic               is_signed, a_neg, b_neg, is_div_op;
   logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix, rem_sub;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0]     mul_sum, rem_sh;

   assign is_signed = (op == OP_MULT) || (op == OP_DIV);
   assign is_div_op = op[1];
   assign a_neg     = is_signed & opr_a[WIDTH-1];
   assign b_neg     = is_signed & opr_b[WIDTH-1];

   muldiv_abs #(.WIDTH(WIDTH))   u_abs_a    (.x(opr_a), .neg(a_neg), .y(a_mag));
   muldiv_abs #(.WIDTH(WIDTH))   u_abs_b    (.x(opr_b), .neg(b_neg), .y(b_mag));
   muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_prod (.x(acc_q), .neg(neg_q), .y(prod_fix));
   muldiv_abs #(.WIDTH(WIDTH))   u_fix_quot (.x(acc_q[WIDTH-1:0]), .neg(neg_q), .y(quot_fix));
   muldiv_abs #(.WIDTH(WIDTH))   u_fix_rem  (.x(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_r_q), .y(rem_fix));

   // Carry out of the partial-product add becomes the top bit after the shift.
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
   assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
   assign rem_sub = rem_sh[WIDTH-1:0] - opd_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opd_d    = opd_q;
      neg_d    = neg_q;
      neg_r_d  = neg_r_q;
      dz_d     = dz_q;
      is_div_d = is_div_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     state_d  = is_div_op ? S_DIV : S_MUL;
                     cnt_d    = '0;
                     acc_d    = {{WIDTH{1'b0}}, (is_div_op ? a_mag : b_mag)};
                     opd_d    = is_div_op ? b_mag : a_mag;
                     neg_d    = a_neg ^ b_neg;
                     neg_r_d  = a_neg;
                     dz_d     = is_div_op && (opr_b == '0);
                     is_div_d = is_div_op;
                  end
                  OP_MTHI: hi_d = opr_a;
                  OP_MTLO: lo_d = opr_a;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) state_d = S_FIX;
         end
         S_DIV: begin
            if (rem_sh >= {1'b0, opd_q}) acc_d = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
            else                         acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = dz_q ? {WIDTH{DIV0_QUOT_BIT}} : quot_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Flush beats everything, including a start or MT write in the same cycle.
      if (flush) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opd_q    <= '0;
         neg_q    <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
         is_div_q <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         neg_q    <= neg_d;
         neg_r_q  <= neg_r_d;
         dz_q     <= dz_d;
         is_div_q <= is_div_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a 64-bit arithmetic reference.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n, start, flush, busy, done;
   logic [2:0]  op;
   logic [31:0] opr_a, opr_b, hi, lo;

   int tests = 0;
   int fails = 0;
   logic [31:0] m_hi, m_lo;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opr_a(opr_a), .opr_b(opr_b),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Architectural result of one op: {hi, lo}.
   function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a, b,
                                          input logic [31:0] h, l);
      longint sa, sb;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = {h, l};
      case (o)
         3'd0: r = 64'(sa * sb);
         3'd1: r = {32'd0, a} * {32'd0, b};
         3'd2: if (b == 0) r = {a, 32'hFFFF_FFFF};
               else        r = {32'(sa % sb), 32'(sa / sb)};
         3'd3: if (b == 0) r = {a, 32'hFFFF_FFFF};
               else        r = {a % b, a / b};
         3'd4: r = {a, l};
         3'd5: r = {h, a};
         default: r = {h, l};
      endcase
      return r;
   endfunction

   // Issue a multi-cycle op and wait for done; returns in the done cycle.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, b, input int restart_at);
      logic [63:0] exp;
      int n, busy_n;
      exp = ref_op(o, a, b, m_hi, m_lo);
      op = o; opr_a = a; opr_b = b; start = 1'b1;
      tick;
      start = 1'b0;
      n = 0; busy_n = 0;
      while (!done && n < 60) begin
         if (busy) busy_n++;
         start = (n == restart_at);
         if (n == restart_at) begin
            op = 3'd1; opr_a = 32'd5; opr_b = 32'd5;
         end
         tick;
         n++;
      end
      start = 1'b0;
      chk("latency", 64'(n), 64'd33);
      chk("busy_cycles", 64'(busy_n), 64'd33);
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("hi", 64'(hi), 64'(exp[63:32]));
      chk("lo", 64'(lo), 64'(exp[31:0]));
      m_hi = exp[63:32];
      m_lo = exp[31:0];
   endtask

   // Single-edge op (MTHI/MTLO/reserved), optionally with flush in the same cycle.
   task automatic run_mt(input logic [2:0] o, input logic [31:0] a, input logic fl);
      logic [63:0] exp;
      exp = fl ? {m_hi, m_lo} : ref_op(o, a, 32'd0, m_hi, m_lo);
      op = o; opr_a = a; start = 1'b1; flush = fl;
      tick;
      start = 1'b0; flush = 1'b0;
      chk("mt_busy", 64'(busy), 64'd0);
      chk("mt_done", 64'(done), 64'd0);
      chk("mt_hi", 64'(hi), 64'(exp[63:32]));
      chk("mt_lo", 64'(lo), 64'(exp[31:0]));
      m_hi = exp[63:32];
      m_lo = exp[31:0];
   endtask

   // Start an op, flush it fl_at cycles later, and confirm it never completes.
   task automatic run_flushed(input logic [2:0] o, input logic [31:0] a, b, input int fl_at);
      int done_n;
      op = o; opr_a = a; opr_b = b; start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < fl_at; i++) tick;
      chk("busy_before_flush", 64'(busy), 64'd1);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_done", 64'(done), 64'd0);
      done_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) done_n++;
         tick;
      end
      chk("flush_no_done", 64'(done_n), 64'd0);
      chk("flush_hi", 64'(hi), 64'(m_hi));
      chk("flush_lo", 64'(lo), 64'(m_lo));
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; opr_a = '0; opr_b = '0;
      m_hi = '0; m_lo = '0;
      #3;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      #9 rst_n = 1'b1;
      tick;

      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
      chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
      chk("multu_max_lo", 64'(lo), 64'h0000_0001);

      run_op(3'd0, -32'sd3, 32'd5, -1);
      chk("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
      chk("mult_neg_lo", 64'(lo), 64'hFFFF_FFF1);
      run_op(3'd2, -32'sd7, 32'd2, -1);
      chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
      chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

      run_op(3'd3, 32'd100, 32'd0, -1);
      chk("divz_lo", 64'(lo), 64'hFFFF_FFFF);
      chk("divz_hi", 64'(hi), 64'h0000_0064);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
      chk("minneg1_lo", 64'(lo), 64'h8000_0000);
      chk("minneg1_hi", 64'(hi), 64'h0);

      tick;
      run_flushed(3'd1, 32'd6, 32'd7, 9);
      run_op(3'd3, 32'd1000, 32'd7, 5);
      chk("restart_lo", 64'(lo), 64'd142);
      chk("restart_hi", 64'(hi), 64'd6);

      run_mt(3'd4, 32'hDEAD_BEEF, 1'b0);
      run_mt(3'd5, 32'h1234_5678, 1'b0);
      chk("mthi_val", 64'(hi), 64'hDEAD_BEEF);
      chk("mtlo_val", 64'(lo), 64'h1234_5678);
      run_mt(3'd5, 32'hCAFE_F00D, 1'b1);
      run_mt(3'd7, 32'h5555_AAAA, 1'b0);

      // Asynchronous reset in the middle of a divide.
      op = 3'd2; opr_a = 32'd12345; opr_b = 32'd17; start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 19; i++) tick;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_hi", 64'(hi), 64'd0);
      chk("arst_lo", 64'(lo), 64'd0);
      m_hi = '0; m_lo = '0;
      #3 rst_n = 1'b1;
      tick;
      run_op(3'd1, 32'd2, 32'd3, -1);
      chk("post_rst_lo", 64'(lo), 64'd6);
      chk("post_rst_hi", 64'(hi), 64'd0);

      // Randomized back-to-back traffic with occasional corner operands.
      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 5));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 9));
            3: ra = -32'($urandom_range(1, 1000));
            default: ;
         endcase
         if (ro >= 3'd4) run_mt(ro, ra, 1'($urandom_range(0, 3) == 0));
         else            run_op(ro, ra, rb, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
